// File: rtl/elevator_scheduler.sv
// SCAN-ordered elevator car controller: holds floor requests in a pending mask
// and sequences car motion and door dwell, exposing floor/direction/status.
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 100_000_000,
    parameter int DOOR_CYCLES   = 300_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [3:0]            req_floor,
    output logic [3:0]            cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrive,
    output logic                  req_reject
);

    // state  | meaning
    // S_IDLE | car parked, choosing the next action from pending requests
    // S_MOVE | travelling one floor per TRAVEL_CYCLES toward a pending request
    // S_DOOR | door open at cur_floor for DOOR_CYCLES

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cur_floor_q, cur_floor_d;
    logic                    dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [TW-1:0]           travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]           door_cnt_q, door_cnt_d;
    logic                    moving_q, moving_d;
    logic                    door_open_q, door_open_d;
    logic                    arrive_q, arrive_d;
    logic                    req_reject_q, req_reject_d;

    logic                    in_range;
    logic                    door_repeat;
    logic                    req_take;
    logic [NUM_FLOORS-1:0]   req_onehot;
    logic [NUM_FLOORS-1:0]   eff_pending;
    logic [NUM_FLOORS-1:0]   here_mask;
    logic                    travel_done;
    logic                    door_done;
    logic [3:0]              next_floor;
    logic [3:0]              ref_floor;
    logic                    above;
    logic                    below;
    logic                    here;

    always_comb begin
        in_range     = ({1'b0, req_floor} < 5'(NUM_FLOORS));
        req_reject_d = req_valid && !in_range;
        // A repeat press of the open door's floor re-arms the dwell instead of queuing a stop.
        door_repeat  = req_valid && in_range && (state_q == S_DOOR) && (req_floor == cur_floor_q);
        req_take     = req_valid && in_range && !door_repeat;

        for (int i = 0; i < NUM_FLOORS; i++) begin
            req_onehot[i] = req_take && (req_floor == 4'(i));
        end
        eff_pending = pending_q | req_onehot;

        travel_done = (state_q == S_MOVE) && (travel_cnt_q == TRAVEL_LAST);
        door_done   = (door_cnt_q == DOOR_LAST);
        next_floor  = dir_up_q ? (cur_floor_q + 4'd1) : (cur_floor_q - 4'd1);
        // On a floor step every decision is taken relative to the floor being entered.
        ref_floor   = travel_done ? next_floor : cur_floor_q;

        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_mask[i] = (ref_floor == 4'(i));
            if (eff_pending[i] && (4'(i) > ref_floor)) above = 1'b1;
            if (eff_pending[i] && (4'(i) < ref_floor)) below = 1'b1;
        end
        here = |(eff_pending & here_mask);

        state_d      = state_q;
        cur_floor_d  = cur_floor_q;
        dir_up_d     = dir_up_q;
        pending_d    = eff_pending;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        arrive_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d    = S_DOOR;
                    pending_d  = eff_pending & ~here_mask;
                    arrive_d   = 1'b1;
                    door_cnt_d = '0;
                end else if (above && (dir_up_q || !below)) begin
                    state_d      = S_MOVE;
                    dir_up_d     = 1'b1;
                    travel_cnt_d = '0;
                end else if (below) begin
                    state_d      = S_MOVE;
                    dir_up_d     = 1'b0;
                    travel_cnt_d = '0;
                end
            end
            S_MOVE: begin
                if (travel_done) begin
                    travel_cnt_d = '0;
                    cur_floor_d  = next_floor;
                    if (here) begin
                        state_d    = S_DOOR;
                        pending_d  = eff_pending & ~here_mask;
                        arrive_d   = 1'b1;
                        door_cnt_d = '0;
                    end else if (dir_up_q ? above : below) begin
                        state_d = S_MOVE;
                    end else if (dir_up_q ? below : above) begin
                        state_d  = S_MOVE;
                        dir_up_d = !dir_up_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + TW'(1);
                end
            end
            S_DOOR: begin
                if (door_repeat) begin
                    door_cnt_d = '0;
                end else if (door_done) begin
                    door_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        moving_d    = (state_d == S_MOVE);
        door_open_d = (state_d == S_DOOR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_floor_q  <= 4'd0;
            dir_up_q     <= 1'b1;
            pending_q    <= '0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
            moving_q     <= 1'b0;
            door_open_q  <= 1'b0;
            arrive_q     <= 1'b0;
            req_reject_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_floor_q  <= cur_floor_d;
            dir_up_q     <= dir_up_d;
            pending_q    <= pending_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
            moving_q     <= moving_d;
            door_open_q  <= door_open_d;
            arrive_q     <= arrive_d;
            req_reject_q <= req_reject_d;
        end
    end

    // The car must never step past the top or bottom floor.
    a_floor_bounds: assert property (@(posedge clk) disable iff (rst)
        travel_done |-> (dir_up_q ? (cur_floor_q != 4'(NUM_FLOORS - 1)) : (cur_floor_q != 4'd0)));

    assign cur_floor  = cur_floor_q;
    assign dir_up     = dir_up_q;
    assign moving     = moving_q;
    assign door_open  = door_open_q;
    assign pending    = pending_q;
    assign arrive     = arrive_q;
    assign req_reject = req_reject_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with NUM_FLOORS=8, TRAVEL_CYCLES=4,
// DOOR_CYCLES=6; expected values are hand-computed cycle by cycle.
module tb_elevator_scheduler;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_floor;
    logic [3:0] cur_floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [7:0] pending;
    logic       arrive;
    logic       req_reject;

    int checks = 0;
    int errors = 0;

    elevator_scheduler #(
        .NUM_FLOORS   (8),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending),
        .arrive    (arrive),
        .req_reject(req_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle request strobe; returns 1 unit after the edge that sampled it.
    task automatic req(input logic [3:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick(1);
        req_valid = 1'b0;
        req_floor = 4'd0;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] f, input logic d, input logic mv,
                           input logic dr, input logic [7:0] p, input logic ar);
        chk({tag, ".cur_floor"}, 32'(cur_floor), 32'(f));
        chk({tag, ".dir_up"},    32'(dir_up),    32'(d));
        chk({tag, ".moving"},    32'(moving),    32'(mv));
        chk({tag, ".door_open"}, 32'(door_open), 32'(dr));
        chk({tag, ".pending"},   32'(pending),   32'(p));
        chk({tag, ".arrive"},    32'(arrive),    32'(ar));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_floor = 4'd0;
        #12;
        chk_all("reset", 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset.req_reject", 32'(req_reject), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        chk_all("idle_after_reset", 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Request for the current floor while idle, then a repeat press during the dwell.
        req(4'd0);
        chk_all("here_idle", 4'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        tick(2);
        req(4'd0);
        chk_all("here_door_restart", 4'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        tick(5);
        chk("door_extended", 32'(door_open), 32'd1);
        tick(1);
        chk_all("door_extended_close", 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Basic trip 0 -> 3.
        req(4'd3);
        chk_all("trip_start", 4'd0, 1'b1, 1'b1, 1'b0, 8'h08, 1'b0);
        tick(3);
        chk("trip_before_step", 32'(cur_floor), 32'd0);
        tick(1);
        chk("trip_floor1", 32'(cur_floor), 32'd1);
        tick(4);
        chk("trip_floor2", 32'(cur_floor), 32'd2);
        tick(4);
        chk_all("trip_arrive3", 4'd3, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        tick(1);
        chk_all("trip_door", 4'd3, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        tick(4);
        chk("trip_door_last", 32'(door_open), 32'd1);
        tick(1);
        chk_all("trip_idle", 4'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Out-of-range requests.
        req(4'd9);
        chk("reject9.pulse", 32'(req_reject), 32'd1);
        chk_all("reject9", 4'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1);
        chk("reject9.end", 32'(req_reject), 32'd0);
        req(4'd15);
        chk("reject15.pulse", 32'(req_reject), 32'd1);
        chk("reject15.pending", 32'(pending), 32'd0);
        req(4'd7);
        chk("valid_no_reject", 32'(req_reject), 32'd0);
        chk_all("after_reject_move", 4'd3, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0);
        // Unwind this trip: 3 -> 7 takes 16 cycles, then the dwell.
        tick(16);
        chk_all("trip7_arrive", 4'd7, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        tick(6);
        chk_all("trip7_idle", 4'd7, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Duplicate requests for floor 5 give a single stop.
        req(4'd5);
        chk_all("dup_start", 4'd7, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
        tick(1);
        req(4'd5);
        chk("dup_pending", 32'(pending), 32'h20);
        tick(5);
        chk_all("dup_floor6", 4'd6, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
        tick(1);
        chk_all("dup_arrive5", 4'd5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        tick(6);
        chk_all("dup_close", 4'd5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1);
        chk_all("dup_no_second_stop", 4'd5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // SCAN: heading up to 7 from 5, add 2 then 6 -> stops 6, 7, then down to 2.
        req(4'd7);
        chk_all("scan_start", 4'd5, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0);
        req(4'd2);
        chk("scan_pend2", 32'(pending), 32'h84);
        req(4'd6);
        chk("scan_pend6", 32'(pending), 32'hC4);
        tick(2);
        chk_all("scan_stop6", 4'd6, 1'b1, 1'b0, 1'b1, 8'h84, 1'b1);
        tick(6);
        chk_all("scan_idle6", 4'd6, 1'b1, 1'b0, 1'b0, 8'h84, 1'b0);
        tick(1);
        chk_all("scan_move_up", 4'd6, 1'b1, 1'b1, 1'b0, 8'h84, 1'b0);
        tick(4);
        chk_all("scan_stop7", 4'd7, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1);
        tick(6);
        chk_all("scan_idle7", 4'd7, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0);
        tick(1);
        chk_all("scan_reverse", 4'd7, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0);
        tick(20);
        chk_all("scan_stop2", 4'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        tick(6);
        chk_all("scan_idle2", 4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Same-cycle arrival: request 3 on the edge the car steps 2 -> 3.
        req(4'd7);
        chk_all("same_start", 4'd2, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0);
        tick(3);
        chk("same_still2", 32'(cur_floor), 32'd2);
        req(4'd3);
        chk_all("same_stop3", 4'd3, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1);
        req(4'd0);
        chk("same_pend81", 32'(pending), 32'h81);
        tick(5);
        chk_all("same_idle3", 4'd3, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0);
        tick(1);
        chk_all("same_move_up", 4'd3, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0);
        tick(4);
        chk_all("pre_reset_floor4", 4'd4, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0);

        // Asynchronous reset mid-move.
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("async_reset.req_reject", 32'(req_reject), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk_all("post_reset_still", 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Elevator car controller that accepts floor requests from the gesture/UART front end, holds them in a pending-request bitmask, and sequences car motion and door dwell using SCAN (elevator) ordering. It sits between the UART receiver's byte/valid output and the seven-segment display path: it consumes decoded floor numbers and produces the current floor, direction, motion and door status that drive the display and indicators.

## Interface
Parameters:
- NUM_FLOORS, 8, number of floors, legal range 2..16; floors are numbered 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 100_000_000, clock cycles to move one floor; must be ≥ 1.
- DOOR_CYCLES, 300_000_000, clock cycles the door stays open per stop; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  single-cycle request strobe (driven by the UART rx valid).
- req_floor  in  4  requested floor, sampled when req_valid=1.
- cur_floor  out  4  current car floor.
- dir_up  out  1  scan direction: 1=up, 0=down.
- moving  out  1  high while in MOVE.
- door_open  out  1  high while in DOOR.
- pending  out  NUM_FLOORS  outstanding request bitmask.
- arrive  out  1  one-cycle pulse on the cycle DOOR is entered.
- req_reject  out  1  one-cycle pulse the cycle after an out-of-range request.

## Operation
- Reset values: state IDLE, cur_floor=0, dir_up=1, pending=0, moving=0, door_open=0, arrive=0, req_reject=0, both counters 0.
- Request acceptance: req_floor ≥ NUM_FLOORS → ignored, req_reject pulses. Otherwise the request is accepted and ORed into pending.
- Exception: a request equal to cur_floor while in DOOR does not set its bit. Instead, the door counter restarts at 0.
- eff_pending = pending | one-hot(accepted request this cycle). All scheduling decisions use eff_pending, so a same-cycle request is never missed.
- above = any eff_pending bit > cur_floor; below = any eff_pending bit < cur_floor; here = eff_pending[cur_floor].
- IDLE:
  - here → DOOR: clear that bit, pulse arrive.
  - else above and (dir_up or !below) → MOVE, dir_up=1.
  - else below → MOVE, dir_up=0.
  - else remain in IDLE.
- MOVE: the travel counter increments each cycle. At count TRAVEL_CYCLES-1 the counter clears, cur_floor steps ±1 per dir_up, and the next state is evaluated at the new floor (nf):
  - eff_pending[nf] → DOOR: clear the bit, pulse arrive.
  - else requests exist beyond nf in the current direction → stay in MOVE.
  - else requests exist in the opposite direction → flip dir_up, stay in MOVE.
  - else → IDLE.
- DOOR: the door counter increments each cycle. At DOOR_CYCLES-1 the counter clears and the state goes to IDLE; direction is retained.
- Bounds: the car only moves toward a set bit, so cur_floor never leaves 0..NUM_FLOORS-1. A step past either end is a design error; an assertion checks for it.
- Duplicate requests are idempotent, because the bit is already set.
- Reset asserted mid-MOVE or mid-DOOR returns everything to reset values immediately. Pending requests are lost.

## Timing
- Request latency: the pending bit is visible on the cycle after req_valid.
- An IDLE decision takes 1 cycle: a request at cycle t in IDLE gives moving=1 or door_open=1 at t+1.
- Floor step: cur_floor updates exactly TRAVEL_CYCLES cycles after MOVE is entered (and after each previous step).
- door_open stays high for exactly DOOR_CYCLES cycles, absent any restart.
- Going from door close to the next move costs one IDLE cycle.
- arrive pulses in the first DOOR cycle, together with the pending bit clearing.
- All outputs are registered.

## Test plan
All scenarios use NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6.
- Basic trip: after reset, request floor 3 → moving=1 next cycle; cur_floor steps 1, 2, 3 at 4-cycle intervals; arrive pulses; door_open high for 6 cycles; then IDLE with pending=0.
- SCAN ordering: car at 2 moving up toward 6; request 1 then 4 mid-travel → stops in order 4, 6, then reverses (dir_up=0) to stop at 1.
- Request for the current floor: while in IDLE at floor 0 → DOOR next cycle, no motion. While in DOOR at floor 0 → door_open extends to 6 cycles after the repeat request, and pending stays 0.
- Out of range and duplicates: req_floor=9 → req_reject pulses and pending is unchanged. Floor 5 requested twice → a single stop at 5.
- Same-cycle arrival request: request floor 3 on the exact cycle the car steps from 2 to 3 (moving up toward 6) → the car stops at 3.
- Reset mid-MOVE at floor 4 with pending=8'b1000_0001 → all outputs return to reset values asynchronously, and no further motion occurs.
